// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite responder exposing num_regs read/write registers with byte strobes.
// Optional: define AXI4_LITE_SLAVE_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axi4_lite_slave_regs #(
    parameter int data_width = 32,
    parameter int num_regs   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      AWvalid,
    output logic                      AWready,
    input  logic [31:0]               AWaddr,
    input  logic                      Wvalid,
    output logic                      Wready,
    input  logic [data_width-1:0]     Wdata,
    input  logic [data_width/8-1:0]   Wstrb,
    output logic                      Bvalid,
    input  logic                      Bready,
    output logic [1:0]                Bresp,
    input  logic                      ARvalid,
    output logic                      ARready,
    input  logic [31:0]               ARaddr,
    output logic                      Rvalid,
    input  logic                      Rready,
    output logic [data_width-1:0]     Rdata,
    output logic [1:0]                Rresp
);

    localparam int          NBYTES   = data_width / 8;
    localparam int          OFFS     = $clog2(NBYTES);
    localparam int          IDXW     = $clog2(num_regs);
    localparam logic [31:0] ADDR_LIM = 32'(num_regs * NBYTES);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
`ifdef AXI4_LITE_SLAVE_SLVERR_EN
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
`endif

    typedef enum logic [1:0] {WR_IDLE, WR_COMMIT, WR_RESP} wr_state_t;
    typedef enum logic       {RD_IDLE, RD_RESP}            rd_state_t;

    logic [data_width-1:0] r_regs [num_regs];

    wr_state_t             r_wr_state, w_wr_state_nxt;
    logic                  r_awready, w_awready_nxt;
    logic                  r_wready, w_wready_nxt;
    logic                  r_aw_have, w_aw_have_nxt;
    logic                  r_w_have, w_w_have_nxt;
    logic [31:0]           r_aw_addr, w_aw_addr_nxt;
    logic [data_width-1:0] r_w_data, w_w_data_nxt;
    logic [NBYTES-1:0]     r_w_strb, w_w_strb_nxt;
    logic                  r_bvalid, w_bvalid_nxt;
    logic [1:0]            r_bresp, w_bresp_nxt;

    rd_state_t             r_rd_state, w_rd_state_nxt;
    logic                  r_arready, w_arready_nxt;
    logic                  r_rvalid, w_rvalid_nxt;
    logic [data_width-1:0] r_rdata, w_rdata_nxt;
    logic [1:0]            r_rresp, w_rresp_nxt;

    logic                  w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic                  w_wr_in_range, w_rd_in_range;
    logic [IDXW-1:0]       w_wr_idx, w_rd_idx;
    logic [1:0]            w_wr_resp, w_rd_resp;

    assign w_aw_hs = AWvalid && r_awready;
    assign w_w_hs  = Wvalid && r_wready;
    assign w_b_hs  = r_bvalid && Bready;
    assign w_ar_hs = ARvalid && r_arready;
    assign w_r_hs  = r_rvalid && Rready;

    // Offset bits are ignored; anything past the bank is out of range.
    assign w_wr_in_range = r_aw_addr < ADDR_LIM;
    assign w_rd_in_range = ARaddr < ADDR_LIM;
    assign w_wr_idx      = r_aw_addr[OFFS +: IDXW];
    assign w_rd_idx      = ARaddr[OFFS +: IDXW];

`ifdef AXI4_LITE_SLAVE_SLVERR_EN
    assign w_wr_resp = w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
    assign w_rd_resp = w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
`else
    assign w_wr_resp = RESP_OKAY;
    assign w_rd_resp = RESP_OKAY;
`endif

    // ---------------- write path ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_state <= WR_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_aw_have  <= 1'b0;
            r_w_have   <= 1'b0;
            r_aw_addr  <= '0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_awready  <= w_awready_nxt;
            r_wready   <= w_wready_nxt;
            r_aw_have  <= w_aw_have_nxt;
            r_w_have   <= w_w_have_nxt;
            r_aw_addr  <= w_aw_addr_nxt;
            r_w_data   <= w_w_data_nxt;
            r_w_strb   <= w_w_strb_nxt;
            r_bvalid   <= w_bvalid_nxt;
            r_bresp    <= w_bresp_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            WR_IDLE:   if ((r_aw_have || w_aw_hs) && (r_w_have || w_w_hs)) w_wr_state_nxt = WR_COMMIT;
            WR_COMMIT: w_wr_state_nxt = WR_RESP;
            WR_RESP:   if (w_b_hs) w_wr_state_nxt = WR_IDLE;
            default:   w_wr_state_nxt = WR_IDLE;
        endcase
    end

    // NOTE: every comb output starts from a hold/default value so no path leaves it unassigned (no latch).
    always_comb begin
        w_awready_nxt = r_awready;
        w_wready_nxt  = r_wready;
        w_aw_have_nxt = r_aw_have;
        w_w_have_nxt  = r_w_have;
        w_aw_addr_nxt = r_aw_addr;
        w_w_data_nxt  = r_w_data;
        w_w_strb_nxt  = r_w_strb;
        w_bvalid_nxt  = r_bvalid;
        w_bresp_nxt   = r_bresp;
        case (r_wr_state)
            WR_IDLE: begin
                if (w_aw_hs) begin
                    w_aw_addr_nxt = AWaddr;
                    w_aw_have_nxt = 1'b1;
                end
                if (w_w_hs) begin
                    w_w_data_nxt = Wdata;
                    w_w_strb_nxt = Wstrb;
                    w_w_have_nxt = 1'b1;
                end
                w_awready_nxt = !w_aw_have_nxt;
                w_wready_nxt  = !w_w_have_nxt;
            end
            WR_COMMIT: begin
                w_bvalid_nxt = 1'b1;
                w_bresp_nxt  = w_wr_resp;
            end
            WR_RESP: begin
                if (w_b_hs) begin
                    w_bvalid_nxt  = 1'b0;
                    w_aw_have_nxt = 1'b0;
                    w_w_have_nxt  = 1'b0;
                    w_aw_addr_nxt = '0;
                    w_w_data_nxt  = '0;
                    w_w_strb_nxt  = '0;
                    w_awready_nxt = 1'b1;
                    w_wready_nxt  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the register bank is a reset-cleared flop array, not a RAM, so it can be cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < num_regs; i++) r_regs[i] <= '0;
        end else if (r_wr_state == WR_COMMIT && w_wr_in_range) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (r_w_strb[b]) r_regs[w_wr_idx][8*b +: 8] <= r_w_data[8*b +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    // NOTE: non-blocking updates mean a read sampled on the commit edge sees the pre-write value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_state <= RD_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_arready  <= w_arready_nxt;
            r_rvalid   <= w_rvalid_nxt;
            r_rdata    <= w_rdata_nxt;
            r_rresp    <= w_rresp_nxt;
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            RD_IDLE: if (w_ar_hs) w_rd_state_nxt = RD_RESP;
            RD_RESP: if (w_r_hs)  w_rd_state_nxt = RD_IDLE;
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        w_arready_nxt = r_arready;
        w_rvalid_nxt  = r_rvalid;
        w_rdata_nxt   = r_rdata;
        w_rresp_nxt   = r_rresp;
        case (r_rd_state)
            RD_IDLE: begin
                w_arready_nxt = !w_ar_hs;
                if (w_ar_hs) begin
                    w_rvalid_nxt = 1'b1;
                    w_rdata_nxt  = w_rd_in_range ? r_regs[w_rd_idx] : '0;
                    w_rresp_nxt  = w_rd_resp;
                end
            end
            RD_RESP: begin
                if (w_r_hs) begin
                    w_rvalid_nxt  = 1'b0;
                    w_arready_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign AWready = r_awready;
    assign Wready  = r_wready;
    assign Bvalid  = r_bvalid;
    assign Bresp   = r_bresp;
    assign ARready = r_arready;
    assign Rvalid  = r_rvalid;
    assign Rdata   = r_rdata;
    assign Rresp   = r_rresp;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Self-checking bench for axi4_lite_slave_regs: directed scenarios plus randomized traffic vs. a register-array model.
module tb_axi4_lite_slave_regs;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        AWvalid = 1'b0, AWready;
    logic [31:0] AWaddr = '0;
    logic        Wvalid = 1'b0, Wready;
    logic [31:0] Wdata = '0;
    logic [3:0]  Wstrb = '0;
    logic        Bvalid, Bready = 1'b1;
    logic [1:0]  Bresp;
    logic        ARvalid = 1'b0, ARready;
    logic [31:0] ARaddr = '0;
    logic        Rvalid, Rready = 1'b1;
    logic [31:0] Rdata;
    logic [1:0]  Rresp;

    int checks = 0;
    int failures = 0;

`ifdef AXI4_LITE_SLAVE_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    logic [31:0] model [16];

    axi4_lite_slave_regs #(.data_width(32), .num_regs(16)) dut (
        .clk(clk), .reset(reset),
        .AWvalid(AWvalid), .AWready(AWready), .AWaddr(AWaddr),
        .Wvalid(Wvalid), .Wready(Wready), .Wdata(Wdata), .Wstrb(Wstrb),
        .Bvalid(Bvalid), .Bready(Bready), .Bresp(Bresp),
        .ARvalid(ARvalid), .ARready(ARready), .ARaddr(ARaddr),
        .Rvalid(Rvalid), .Rready(Rready), .Rdata(Rdata), .Rresp(Rresp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model (16 x 32-bit bank at 0x00..0x3F) ----------------
    function automatic logic [1:0] exp_resp(input logic [31:0] addr);
        return (SLVERR_EN && addr >= 32'd64) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        return (addr < 32'd64) ? model[addr[5:2]] : 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if (addr < 32'd64)
            for (int i = 0; i < 4; i++)
                if (strb[i]) model[addr[5:2]][8*i +: 8] = data[8*i +: 8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
    endtask

    // ---------------- bus drivers (start and end on a falling edge) ----------------
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_delay, input int w_delay,
                             output logic [1:0] resp, output int lat, output bit early_wready);
        bit aw_done, w_done, aw_hs, w_hs;
        int c;
        aw_done = 0; w_done = 0; c = 0; early_wready = 0; lat = -1; resp = 2'bxx;
        Bready = 1'b1;
        while (!(aw_done && w_done)) begin
            if (c >= 200) begin
                checks++; failures++;
                $display("FAIL write_handshake_timeout: addr=%h aw_done=%0d w_done=%0d", addr, aw_done, w_done);
                AWvalid = 1'b0; Wvalid = 1'b0;
                return;
            end
            if (!aw_done && c >= aw_delay) begin AWvalid = 1'b1; AWaddr = addr; end
            if (!w_done && c >= w_delay) begin Wvalid = 1'b1; Wdata = data; Wstrb = strb; end
            aw_hs = AWvalid && AWready;
            w_hs  = Wvalid && Wready;
            @(posedge clk); @(negedge clk);
            if (aw_hs) begin aw_done = 1; AWvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  Wvalid = 1'b0; end
            if (w_done && !aw_done && Wready) early_wready = 1;
            c++;
        end
        lat = 0;
        while (!Bvalid) begin
            if (lat >= 50) begin
                checks++; failures++;
                $display("FAIL write_bvalid_timeout: addr=%h", addr);
                lat = -1;
                return;
            end
            @(posedge clk); @(negedge clk);
            lat++;
        end
        resp = Bresp;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                            output int lat);
        int c;
        data = 'x; resp = 2'bxx; lat = -1; c = 0;
        ARvalid = 1'b1; ARaddr = addr; Rready = 1'b1;
        while (!ARready) begin
            if (c >= 50) begin
                checks++; failures++;
                $display("FAIL read_arready_timeout: addr=%h", addr);
                ARvalid = 1'b0;
                return;
            end
            @(posedge clk); @(negedge clk);
            c++;
        end
        @(posedge clk); @(negedge clk);
        ARvalid = 1'b0;
        lat = 0;
        while (!Rvalid) begin
            if (lat >= 50) begin
                checks++; failures++;
                $display("FAIL read_rvalid_timeout: addr=%h", addr);
                lat = -1;
                return;
            end
            @(posedge clk); @(negedge clk);
            lat++;
        end
        data = Rdata; resp = Rresp;
        @(posedge clk); @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [40:0] outs;
        reset = 1'b0;
        model_clear();
        #1;
        outs = {AWready, Wready, ARready, Bvalid, Rvalid, Bresp, Rresp, Rdata};
        checks++; if (outs !== '0) begin failures++; $display("FAIL reset_outputs: got %h exp 0", outs); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        outs = {AWready, Wready, ARready, Bvalid, Rvalid, Bresp, Rresp, Rdata};
        checks++; if (outs !== '0) begin failures++; $display("FAIL reset_held_outputs: got %h exp 0", outs); end
        reset = 1'b1;
        #1;
        checks++; if ({AWready, Wready, ARready} !== 3'b000) begin failures++; $display("FAIL reset_release_readies_early: got %b exp 000", {AWready, Wready, ARready}); end
        @(negedge clk);
        checks++; if ({AWready, Wready, ARready} !== 3'b111) begin failures++; $display("FAIL reset_first_edge_readies: got %b exp 111", {AWready, Wready, ARready}); end
    endtask

    task automatic test_same_edge();
        logic [1:0] resp; logic [31:0] data; int lat; bit ew;
        axi_write(32'h4, 32'hAAAACCCC, 4'hF, 0, 0, resp, lat, ew);
        model_write(32'h4, 32'hAAAACCCC, 4'hF);
        checks++; if (lat !== 1) begin failures++; $display("FAIL same_edge_write_latency: got %0d exp 1", lat); end
        checks++; if (resp !== 2'b00) begin failures++; $display("FAIL same_edge_bresp: got %b exp 00", resp); end
        checks++; if (Bvalid !== 1'b0) begin failures++; $display("FAIL same_edge_bvalid_clear: got %b exp 0", Bvalid); end
        axi_read(32'h4, data, resp, lat);
        checks++; if (lat !== 0) begin failures++; $display("FAIL same_edge_read_latency: got %0d exp 0", lat); end
        checks++; if (data !== model_read(32'h4)) begin failures++; $display("FAIL same_edge_rdata: got %h exp %h", data, model_read(32'h4)); end
        checks++; if (resp !== 2'b00) begin failures++; $display("FAIL same_edge_rresp: got %b exp 00", resp); end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp; logic [31:0] data; int lat; bit ew;
        axi_write(32'h8, 32'h12345678, 4'hF, 3, 0, resp, lat, ew);
        model_write(32'h8, 32'h12345678, 4'hF);
        checks++; if (ew !== 1'b0) begin failures++; $display("FAIL w_first_wready_low: got wready=1 while waiting for AW exp 0"); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL w_first_write_latency: got %0d exp 1", lat); end
        axi_read(32'h8, data, resp, lat);
        checks++; if (data !== model_read(32'h8)) begin failures++; $display("FAIL w_first_rdata: got %h exp %h", data, model_read(32'h8)); end
    endtask

    task automatic test_strobes();
        logic [1:0] resp; logic [31:0] data; int lat; bit ew;
        axi_write(32'h4, 32'hFFFFFFFF, 4'b0101, 0, 1, resp, lat, ew);
        model_write(32'h4, 32'hFFFFFFFF, 4'b0101);
        axi_read(32'h4, data, resp, lat);
        checks++; if (data !== model_read(32'h4)) begin failures++; $display("FAIL strobe_0101_rdata: got %h exp %h", data, model_read(32'h4)); end
        axi_write(32'h4, 32'h01234567, 4'b0000, 1, 0, resp, lat, ew);
        checks++; if (resp !== 2'b00) begin failures++; $display("FAIL strobe_zero_bresp: got %b exp 00", resp); end
        axi_read(32'h4, data, resp, lat);
        checks++; if (data !== model_read(32'h4)) begin failures++; $display("FAIL strobe_zero_rdata: got %h exp %h", data, model_read(32'h4)); end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; logic [31:0] data; int lat; bit ew;
        axi_write(32'h40, $urandom, 4'hF, 0, 0, resp, lat, ew);
        checks++; if (resp !== exp_resp(32'h40)) begin failures++; $display("FAIL oor_bresp: got %b exp %b", resp, exp_resp(32'h40)); end
        axi_read(32'h40, data, resp, lat);
        checks++; if (resp !== exp_resp(32'h40)) begin failures++; $display("FAIL oor_rresp: got %b exp %b", resp, exp_resp(32'h40)); end
        checks++; if (data !== 32'h0) begin failures++; $display("FAIL oor_rdata: got %h exp 0", data); end
        for (int i = 0; i < 16; i++) begin
            axi_read(32'(i * 4), data, resp, lat);
            checks++; if (data !== model_read(32'(i * 4))) begin failures++; $display("FAIL oor_bank_intact[%0d]: got %h exp %h", i, data, model_read(32'(i * 4))); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] wdata, exp_rd;
        logic [1:0]  exp_b;
        wdata = $urandom;
        exp_b = exp_resp(32'hC);
        checks++; if ({AWready, Wready, ARready} !== 3'b111) begin failures++; $display("FAIL bp_idle_readies: got %b exp 111", {AWready, Wready, ARready}); end
        Bready = 1'b0; Rready = 1'b0;
        AWvalid = 1'b1; AWaddr = 32'hC; Wvalid = 1'b1; Wdata = wdata; Wstrb = 4'hF;
        ARvalid = 1'b1; ARaddr = 32'h8;
        exp_rd = model_read(32'h8);
        @(posedge clk); @(negedge clk);
        AWvalid = 1'b0; Wvalid = 1'b0; ARvalid = 1'b0;
        model_write(32'hC, wdata, 4'hF);
        checks++; if ({Bvalid, Rvalid} !== 2'b01) begin failures++; $display("FAIL bp_first_edge_valids: got %b exp 01", {Bvalid, Rvalid}); end
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({Bvalid, Rvalid, AWready, Wready, ARready} !== 5'b11000 || Rdata !== exp_rd || Bresp !== exp_b || Rresp !== 2'b00) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got v/rdy=%b rdata=%h bresp=%b rresp=%b exp 11000 %h %b 00",
                         i, {Bvalid, Rvalid, AWready, Wready, ARready}, Rdata, Bresp, Rresp, exp_rd, exp_b);
            end
            @(posedge clk); @(negedge clk);
        end
        Bready = 1'b1; Rready = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if ({Bvalid, Rvalid, AWready, Wready, ARready} !== 5'b00111) begin failures++; $display("FAIL bp_release: got %b exp 00111", {Bvalid, Rvalid, AWready, Wready, ARready}); end
    endtask

    task automatic test_random();
        logic [1:0] resp; logic [31:0] data, addr, wd; logic [3:0] st; int lat; bit ew;
        for (int n = 0; n < 60; n++) begin
            addr = 32'($urandom_range(0, 79));
            if ($urandom_range(0, 1) == 0) begin
                wd = $urandom; st = 4'($urandom_range(0, 15));
                axi_write(addr, wd, st, $urandom_range(0, 3), $urandom_range(0, 3), resp, lat, ew);
                model_write(addr, wd, st);
                checks++; if (resp !== exp_resp(addr) || lat !== 1) begin failures++; $display("FAIL rand_write[%0d]: addr=%h got resp=%b lat=%0d exp resp=%b lat=1", n, addr, resp, lat, exp_resp(addr)); end
            end else begin
                axi_read(addr, data, resp, lat);
                checks++; if (data !== model_read(addr) || resp !== exp_resp(addr) || lat !== 0) begin failures++; $display("FAIL rand_read[%0d]: addr=%h got %h/%b/%0d exp %h/%b/0", n, addr, data, resp, lat, model_read(addr), exp_resp(addr)); end
            end
        end
        for (int i = 0; i < 16; i++) begin
            axi_read(32'(i * 4), data, resp, lat);
            checks++; if (data !== model_read(32'(i * 4))) begin failures++; $display("FAIL rand_sweep[%0d]: got %h exp %h", i, data, model_read(32'(i * 4))); end
        end
    endtask

    task automatic test_reset_mid_commit();
        logic [1:0] resp; logic [31:0] data; int lat; bit ew;
        logic [4:0] outs;
        axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, resp, lat, ew);
        model_write(32'h10, 32'hDEADBEEF, 4'hF);
        AWvalid = 1'b1; AWaddr = 32'h10; Wvalid = 1'b1; Wdata = 32'h5A5A5A5A; Wstrb = 4'hF;
        @(posedge clk); @(negedge clk);
        AWvalid = 1'b0; Wvalid = 1'b0;
        reset = 1'b0;
        model_clear();
        #1;
        outs = {AWready, Wready, ARready, Bvalid, Rvalid};
        checks++; if (outs !== 5'b0) begin failures++; $display("FAIL midreset_immediate: got %b exp 00000", outs); end
        @(posedge clk); @(negedge clk);
        outs = {AWready, Wready, ARready, Bvalid, Rvalid};
        checks++; if (outs !== 5'b0) begin failures++; $display("FAIL midreset_held: got %b exp 00000", outs); end
        reset = 1'b1;
        @(negedge clk);
        axi_read(32'h10, data, resp, lat);
        checks++; if (data !== model_read(32'h10)) begin failures++; $display("FAIL midreset_target: got %h exp %h", data, model_read(32'h10)); end
        axi_read(32'h8, data, resp, lat);
        checks++; if (data !== model_read(32'h8)) begin failures++; $display("FAIL midreset_other: got %h exp %h", data, model_read(32'h8)); end
    endtask

    initial begin
        test_reset();
        test_same_edge();
        test_w_before_aw();
        test_strobes();
        test_out_of_range();
        test_backpressure();
        test_random();
        test_reset_mid_commit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_regs.md
# axi4_lite_slave_regs

AXI4-Lite responder exposing a bank of `num_regs` read/write registers to the AXI4-Lite initiator (`AXI4_Lite_interface`). Sits at the far end of the same five channels the initiator drives: accepts write address/data in either order, applies byte strobes, and answers with write and read responses. Read and write paths are independent state machines sharing only the register array.

## Interface
Parameters:
- `data_width`, 32: data bus width in bits; a multiple of 8.
- `num_regs`, 16: number of registers; a power of two, ≥ 2.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `AWvalid` in 1 / `AWready` out 1 / `AWaddr` in 32: write address channel.
- `Wvalid` in 1 / `Wready` out 1 / `Wdata` in `data_width` / `Wstrb` in `data_width/8`: write data channel.
- `Bvalid` out 1 / `Bready` in 1 / `Bresp` out 2: write response channel.
- `ARvalid` in 1 / `ARready` out 1 / `ARaddr` in 32: read address channel.
- `Rvalid` out 1 / `Rready` in 1 / `Rdata` out `data_width` / `Rresp` out 2: read data channel.

## Operation
- Decode: byte offset bits = log2(`data_width`/8); index = next log2(`num_regs`) address bits. Address in range iff addr < `num_regs`·(`data_width`/8); offset bits ignored.
- Write FSM, states WR_IDLE → WR_COMMIT → WR_RESP → WR_IDLE.
  - WR_IDLE: `AWready`=1 until AW handshake, then 0 with address latched; `Wready`=1 until W handshake, then 0 with data/strobe latched. Either order, or same edge.
  - Edge where the second of AW/W completes (or both together) → WR_COMMIT.
  - WR_COMMIT (one cycle): at its closing edge, byte lane i of the selected register takes `Wdata` lane i iff `Wstrb[i]`=1; `Bvalid`←1, `Bresp` set; → WR_RESP.
  - WR_RESP: `Bvalid`, `Bresp` held until `Bvalid`&&`Bready`; on that edge `Bvalid`←0, latches cleared, readies ←1, → WR_IDLE.
- Read FSM, states RD_IDLE → RD_RESP → RD_IDLE.
  - RD_IDLE: `ARready`=1. On `ARvalid`&&`ARready` edge: `Rdata` ← register (0 if out of range), `Rresp` set, `Rvalid`←1, `ARready`←0, → RD_RESP.
  - RD_RESP: `Rdata`/`Rresp` stable; on `Rvalid`&&`Rready` edge `Rvalid`←0, `ARready`←1, → RD_IDLE.
- `Wstrb`=0: no register change, OKAY response.
- Out-of-range write: no register changes.
- Same-edge AR handshake and WR_COMMIT to the same register: read returns pre-write value.

## Timing
- Reset (asserted, asynchronous): all registers 0; `AWready`, `Wready`, `ARready`, `Bvalid`, `Rvalid` = 0; `Rdata` = 0; `Bresp` = `Rresp` = 2'b00; both FSMs in IDLE; latches cleared.
- First rising edge after `reset` deasserts: `AWready`, `Wready`, `ARready` ←1.
- Reset mid-transaction: transaction dropped; no partial register update; outputs to reset values immediately.
- Write latency: last AW/W handshake at edge k → register updated and `Bvalid`=1 after edge k+1.
- Read latency: AR handshake at edge k → `Rvalid`=1 after edge k.
- Throughput: one write per 3 cycles and one read per 2 cycles minimum, with ready responses held high; read and write proceed concurrently.
- Outputs are registered; no combinational path from any input to any output.

## Configuration
- `AXI4_LITE_SLAVE_SLVERR_EN` defined: out-of-range accesses return `Bresp`/`Rresp` = 2'b10 (SLVERR); in-range accesses return 2'b00.
- Not defined: all responses 2'b00 (OKAY); out-of-range writes are silently dropped and reads return 0.

## Test plan
- Reset, then AW (0x4) and W (0xAAAACCCC, strobe 4'hF) on the same edge, `Bready`=1 → `Bvalid` after 2 edges with `Bresp`=00; then AR 0x4 → `Rvalid` after 1 edge with `Rdata`=0xAAAACCCC.
- W sent 3 cycles before AW (0x8, 0x12345678) → `Wready` low after the W handshake; write completes after AW; readback of 0x8 = 0x12345678.
- Register 0x4 holds 0xAAAACCCC; write 0xFFFFFFFF with strobe 4'b0101 → readback 0xAAFFCCFF; write with strobe 0 → unchanged.
- Write then read at 0x40 with `num_regs`=16 → with macro, `Bresp`=`Rresp`=10, `Rdata`=0; without macro, both responses 00, `Rdata`=0; no register modified.
- `Bready` and `Rready` held low for 5 cycles → `Bvalid`/`Rvalid` and data stable, `AWready`/`Wready`/`ARready` stay 0 until the response handshake.
- `reset` asserted during WR_COMMIT → target register reads 0 after reset; all valids and readies 0 while reset is low.
